// File: rtl/byte_gather_4_if.sv
// Byte-stream in / packed 4-lane word out bundle for byte_gather_4.
// out_parity exists only when BYTE_GATHER_PARITY_EN is defined.
interface byte_gather_4_if #(
    parameter int unsigned BYTE_W = 8
);
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [BYTE_W-1:0] s0;
    logic [BYTE_W-1:0] s1;
    logic [BYTE_W-1:0] s2;
    logic [BYTE_W-1:0] s3;
    logic [2:0]        out_count;
    logic              out_valid;
    logic              out_ready;
`ifdef BYTE_GATHER_PARITY_EN
    logic [3:0]        out_parity;
`endif

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, s0, s1, s2, s3, out_count, out_valid
`ifdef BYTE_GATHER_PARITY_EN
        , output out_parity
`endif
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, s0, s1, s2, s3, out_count, out_valid
`ifdef BYTE_GATHER_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/byte_gather_4.sv
// Packs a byte stream into 4-lane words with an assembly + output register pair.
// Optional BYTE_GATHER_PARITY_EN adds per-lane even parity (out_parity).
module byte_gather_4 #(
    parameter int unsigned       BYTE_W   = 8,
    parameter logic [BYTE_W-1:0] PAD_BYTE = '0
) (
    input  logic            clk,
    input  logic            rst,
    byte_gather_4_if.slave  bus
);
    localparam int unsigned LANES = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 3;

    typedef enum logic {ST_FILL, ST_PEND} state_t;
    typedef logic [LANES-1:0][BYTE_W-1:0] word_t;

    localparam word_t PAD_WORD = {LANES{PAD_BYTE}};

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    word_t             r_asm, w_asm_nxt, w_fill, w_word;
    logic [CNT_W-1:0]  r_pend_cnt, w_pend_cnt_nxt, w_word_cnt;
    word_t             r_lane, w_lane_nxt;
    logic [CNT_W-1:0]  r_out_cnt, w_out_cnt_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic              r_in_ready, w_in_ready_nxt;
    logic              w_accept, w_out_free, w_load;
`ifdef BYTE_GATHER_PARITY_EN
    logic [LANES-1:0]  r_parity, w_parity_nxt;
`endif

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_out_free = !r_out_valid || bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_FILL;
        else      r_state <= w_state_nxt;
    end

    // Next-state, assembly and output-register next values
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_asm_nxt       = r_asm;
        w_pend_cnt_nxt  = r_pend_cnt;
        w_lane_nxt      = r_lane;
        w_out_cnt_nxt   = r_out_cnt;
        w_out_valid_nxt = r_out_valid;
        w_load          = 1'b0;
        w_word          = r_asm;
        w_word_cnt      = r_pend_cnt;
        w_fill          = r_asm;
        w_fill[r_idx]   = bus.in_data;

        case (r_state)
            ST_FILL: begin
                if (w_accept) begin
                    if (r_idx == IDX_W'(LANES - 1) || bus.in_last) begin
                        w_word     = w_fill;
                        w_word_cnt = CNT_W'(r_idx) + CNT_W'(1);
                        if (w_out_free) begin
                            w_load    = 1'b1;
                            w_asm_nxt = PAD_WORD;
                            w_idx_nxt = '0;
                        end else begin
                            w_asm_nxt      = w_fill;
                            w_pend_cnt_nxt = w_word_cnt;
                            w_state_nxt    = ST_PEND;
                        end
                    end else begin
                        w_asm_nxt = w_fill;
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_PEND: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_asm_nxt   = PAD_WORD;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase

        // A load in the same cycle as a drain keeps out_valid high (no bubble)
        if (w_load) begin
            w_lane_nxt      = w_word;
            w_out_cnt_nxt   = w_word_cnt;
            w_out_valid_nxt = 1'b1;
        end else if (r_out_valid && bus.out_ready) begin
            w_out_cnt_nxt   = '0;
            w_out_valid_nxt = 1'b0;
        end

        w_in_ready_nxt = (w_state_nxt == ST_FILL);
    end

`ifdef BYTE_GATHER_PARITY_EN
    always_comb begin
        w_parity_nxt = r_parity;
        if (w_load) begin
            w_parity_nxt[0] = ^w_word[0];
            w_parity_nxt[1] = ^w_word[1];
            w_parity_nxt[2] = ^w_word[2];
            w_parity_nxt[3] = ^w_word[3];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_parity <= '0;
        else      r_parity <= w_parity_nxt;
    end

    assign bus.out_parity = r_parity;
`endif

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx       <= '0;
            r_asm       <= PAD_WORD;
            r_pend_cnt  <= '0;
            r_lane      <= PAD_WORD;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_asm       <= w_asm_nxt;
            r_pend_cnt  <= w_pend_cnt_nxt;
            r_lane      <= w_lane_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.s0        = r_lane[0];
    assign bus.s1        = r_lane[1];
    assign bus.s2        = r_lane[2];
    assign bus.s3        = r_lane[3];
    assign bus.out_count = r_out_cnt;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_byte_gather_4.sv
// Directed bench for byte_gather_4: reset, packing, backpressure, flush, parity.
module tb_byte_gather_4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    byte_gather_4_if #(.BYTE_W(8)) bus ();

    byte_gather_4 #(.BYTE_W(8), .PAD_BYTE(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input logic [2:0] ecnt, input logic evld);
        chk({tag, "_s0"},  32'(bus.s0), 32'(e0));
        chk({tag, "_s1"},  32'(bus.s1), 32'(e1));
        chk({tag, "_s2"},  32'(bus.s2), 32'(e2));
        chk({tag, "_s3"},  32'(bus.s3), 32'(e3));
        chk({tag, "_cnt"}, 32'(bus.out_count), 32'(ecnt));
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'(evld));
    endtask

    task automatic send(input logic [7:0] b, input logic last, input string tag);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        step();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    initial begin
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset and release
        step(); step();
        chk("rst_rdy", 32'(bus.in_ready), 32'd0);
        chk_word("rst", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
        rst = 1'b1;
        step();
        chk("rel_rdy", 32'(bus.in_ready), 32'd1);

        // Mid-word reset discards F0,2E
        send(8'hF0, 1'b0, "mr0");
        send(8'h2E, 1'b0, "mr1");
        idle();
        rst = 1'b0;
        #1;
        chk("mr_rdy", 32'(bus.in_ready), 32'd0);
        chk_word("mr", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
        step(); step();
        rst = 1'b1;
        step();
        send(8'h11, 1'b1, "mr2");
        idle();
        chk_word("mr_w", 8'h11, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1);
        step();
        chk("mr_drain_vld", 32'(bus.out_valid), 32'd0);

        // Back-to-back full word, valid exactly one cycle
        send(8'hF0, 1'b0, "b0");
        send(8'h2E, 1'b0, "b1");
        send(8'h27, 1'b0, "b2");
        send(8'hC0, 1'b0, "b3");
        idle();
        chk_word("b2b", 8'hF0, 8'h2E, 8'h27, 8'hC0, 3'd4, 1'b1);
`ifdef BYTE_GATHER_PARITY_EN
        chk("b2b_par", 32'(bus.out_parity), 32'h0);
`endif
        step();
        chk_word("b2b_done", 8'hF0, 8'h2E, 8'h27, 8'hC0, 3'd0, 1'b0);

        // Backpressure: second word pends, then follows with no bubble
        bus.out_ready = 1'b0;
        send(8'h01, 1'b0, "bp1");
        send(8'h02, 1'b0, "bp2");
        send(8'h03, 1'b0, "bp3");
        send(8'h04, 1'b0, "bp4");
        chk_word("bp_w1", 8'h01, 8'h02, 8'h03, 8'h04, 3'd4, 1'b1);
        send(8'h05, 1'b0, "bp5");
        send(8'h06, 1'b0, "bp6");
        send(8'h07, 1'b0, "bp7");
        send(8'h08, 1'b0, "bp8");
        idle();
        chk("bp_pend_rdy", 32'(bus.in_ready), 32'd0);
        chk_word("bp_hold", 8'h01, 8'h02, 8'h03, 8'h04, 3'd4, 1'b1);
        step();
        chk("bp_pend_rdy2", 32'(bus.in_ready), 32'd0);
        chk_word("bp_hold2", 8'h01, 8'h02, 8'h03, 8'h04, 3'd4, 1'b1);
        bus.out_ready = 1'b1;
        step();
        chk_word("bp_w2", 8'h05, 8'h06, 8'h07, 8'h08, 3'd4, 1'b1);
        chk("bp_rdy_back", 32'(bus.in_ready), 32'd1);
        step();
        chk("bp_drain_vld", 32'(bus.out_valid), 32'd0);

        // Partial flushes
        send(8'hAA, 1'b0, "pf0");
        send(8'hBB, 1'b1, "pf1");
        chk_word("pf_ab", 8'hAA, 8'hBB, 8'h00, 8'h00, 3'd2, 1'b1);
        send(8'hCC, 1'b1, "pf2");
        chk_word("pf_cc", 8'hCC, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1);
        send(8'h5A, 1'b1, "pf3");
        chk_word("pf_5a", 8'h5A, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1);
        send(8'h11, 1'b0, "pf4");
        send(8'h22, 1'b0, "pf5");
        send(8'h33, 1'b0, "pf6");
        send(8'h44, 1'b1, "pf7");
        idle();
        chk_word("pf_full", 8'h11, 8'h22, 8'h33, 8'h44, 3'd4, 1'b1);
        step();

        // Idle gap with in_last but no in_valid is ignored
        send(8'h12, 1'b0, "gp0");
        idle();
        bus.in_last = 1'b1;
        step(); step(); step();
        chk("gp_vld", 32'(bus.out_valid), 32'd0);
        bus.in_last = 1'b0;
        send(8'h34, 1'b0, "gp1");
        send(8'h56, 1'b0, "gp2");
        send(8'h78, 1'b0, "gp3");
        idle();
        chk_word("gp_w", 8'h12, 8'h34, 8'h56, 8'h78, 3'd4, 1'b1);
        step();

        // Parity pattern word
        send(8'h01, 1'b0, "py0");
        send(8'h03, 1'b0, "py1");
        send(8'h07, 1'b0, "py2");
        send(8'h00, 1'b0, "py3");
        idle();
        chk_word("py_w", 8'h01, 8'h03, 8'h07, 8'h00, 3'd4, 1'b1);
`ifdef BYTE_GATHER_PARITY_EN
        chk("py_par", 32'(bus.out_parity), 32'h5);
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/byte_gather_4.md
Name: byte_gather_4

Overview:
Upstream feeder for the 4-lane load stage. Accepts a byte stream with a valid/ready handshake and packs consecutive bytes into lanes s0..s3, first byte into s0. Presents each packed word with out_valid/out_ready so the load stage sees stable lane values for a whole transfer. Double-buffered (assembly register plus output register) so the byte stream can run at one byte per cycle with no bubbles.

Parameters:
BYTE_W, 8, width of each byte lane and of in_data.
PAD_BYTE, 8'h00, value written into unfilled lanes when a partial word is flushed by in_last.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset; asynchronous, active-low (0 = reset).
in_data  input  BYTE_W  incoming byte.
in_valid  input  1  in_data is valid.
in_last  input  1  qualifies the current byte as the final byte of a packet; forces a flush.
in_ready  output  1  block can accept a byte this cycle.
s0  output  BYTE_W  lane 0, first byte of the word.
s1  output  BYTE_W  lane 1.
s2  output  BYTE_W  lane 2.
s3  output  BYTE_W  lane 3, fourth byte of the word.
out_count  output  3  number of real bytes in the word (1..4); 0 when out_valid=0.
out_valid  output  1  s0..s3 and out_count hold a word.
out_ready  input  1  downstream consumes the word this cycle.

Behaviour:
- Byte accept: in_valid && in_ready at a rising edge. Word transfer: out_valid && out_ready.
- Reset (rst=0, asynchronous): s0..s3 = PAD_BYTE, out_count=0, out_valid=0, fill index=0, assembly state=FILL. in_ready is 0 while rst=0 and 1 in the first cycle after release.
- Assembly FSM has two states, FILL and PEND.
  - FILL: in_ready=1. An accepted byte goes to lane[idx], and idx increments.
  - When the 4th byte is accepted (idx=3), or any byte is accepted with in_last=1, the word is complete. The complete word moves to the output register if the output register is free. Otherwise the FSM enters PEND.
  - PEND: in_ready=0 and the assembly register is held. The FSM leaves PEND in the cycle the output register frees (out_ready=1 with out_valid=1, or out_valid=0). In that cycle the word transfers and the FSM returns to FILL with idx=0.
- Output register "free" means out_valid=0, or out_valid=1 && out_ready=1 in the same cycle. A simultaneous drain and load must not produce a bubble: out_valid stays 1 and the new word appears on the next cycle.
- Latency: the completing byte is accepted at edge N; out_valid=1 with the new lanes from edge N, visible in cycle N+1. Sustained throughput is one byte per cycle and one word per 4 cycles when out_ready=1.
- Partial flush: in_last on a byte with idx=k<3 sets out_count=k+1. Lanes above k are filled with PAD_BYTE.
- in_last on a byte with idx=3 gives a normal full word, out_count=4.
- While out_valid=1 && out_ready=0, s0..s3 and out_count are held stable.
- in_valid=0 leaves idx and partial lanes unchanged indefinitely. There is no timeout flush.
- in_last with in_valid=0 is ignored.
- Reset mid-word or mid-hold discards any partial and pending data. No word is emitted for discarded data.
- The assembly register is initialised to PAD_BYTE at reset and after each transfer, so stale bytes never leak into padded lanes.

Optional Feature:
BYTE_GATHER_PARITY_EN
- Defined: adds output out_parity[3:0]. Bit i is the XOR-reduction (even parity) of lane si. It is registered with the lanes, held with them, and reset to 0.
- Padded lanes report the parity of PAD_BYTE.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, then hold rst=0 for 2 cycles mid-stream after bytes F0,2E -> out_valid=0, out_count=0, lanes=00. After release, in_ready=1 and the next accepted byte lands in s0.
- Back-to-back bytes F0,2E,27,C0 with out_ready=1 -> one cycle after C0 is accepted: s0=F0, s1=2E, s2=27, s3=C0, out_count=4, out_valid=1 for exactly 1 cycle.
- Send 8 bytes 01..08 continuously with out_ready=0 -> word 01,02,03,04 held. Bytes 05..08 are accepted, then in_ready=0 (PEND). Raise out_ready -> word 05,06,07,08 follows on the next cycle with no bubble, then in_ready=1.
- Bytes AA,BB with in_last=1 on BB -> s0=AA, s1=BB, s2=00, s3=00, out_count=2. The next byte CC lands in s0.
- in_last=1 on the single byte 5A, then on the 4th byte of 11,22,33,44 -> word {5A,00,00,00}, out_count=1, then word {11,22,33,44}, out_count=4.
- (BYTE_GATHER_PARITY_EN) word F0,2E,27,C0 -> out_parity=4'b0000. Word 01,03,07,00 -> out_parity=4'b0101.
